// File: rtl/vga_timing_pkg.sv
// 640x480@60 VGA timing constants, shared by the sync generator and the snake renderer.
package vga_timing_pkg;

    localparam int unsigned HVis   = 640;
    localparam int unsigned HFp    = 16;
    localparam int unsigned HSync  = 96;
    localparam int unsigned HBp    = 48;
    localparam int unsigned HTotal = HVis + HFp + HSync + HBp;

    localparam int unsigned VVis   = 480;
    localparam int unsigned VFp    = 10;
    localparam int unsigned VSync  = 2;
    localparam int unsigned VBp    = 33;
    localparam int unsigned VTotal = VVis + VFp + VSync + VBp;

    localparam int unsigned CoordW = 10;

    // Both syncs are active-low in this mode.
    localparam logic SyncActive = 1'b0;

    function automatic logic sync_level(input logic in_pulse);
        return in_pulse ? SyncActive : ~SyncActive;
    endfunction

endpackage

// File: rtl/pixel_strobe_gen.sv
// Divide-by-DIV prescaler producing a one-clk enable strobe; also reused for the game tick.
module pixel_strobe_gen #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic pixel_en
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);

    logic [CntW-1:0] div_cnt_q, div_cnt_d;

    always_comb begin
        div_cnt_d = div_cnt_q + 1'b1;
        if (div_cnt_q == CntLast) begin
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    assign pixel_en = (div_cnt_q == CntLast);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster counters, sync/blank decode and frame strobe, stepped by the pixel-rate enable.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned DIV    = 4,
    parameter int unsigned H_VIS  = HVis,
    parameter int unsigned H_FP   = HFp,
    parameter int unsigned H_SYNC = HSync,
    parameter int unsigned H_BP   = HBp,
    parameter int unsigned V_VIS  = VVis,
    parameter int unsigned V_FP   = VFp,
    parameter int unsigned V_SYNC = VSync,
    parameter int unsigned V_BP   = VBp
) (
    input  logic              clk,
    input  logic              rst,
    output logic              pixel_en,
    output logic [CoordW-1:0] pixel_x,
    output logic [CoordW-1:0] pixel_y,
    output logic              hsync,
    output logic              vsync,
    output logic              video_on,
    output logic              frame_tick
);

    localparam int unsigned HTot = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned VTot = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [CoordW-1:0] HLast      = CoordW'(HTot - 1);
    localparam logic [CoordW-1:0] VLast      = CoordW'(VTot - 1);
    localparam logic [CoordW-1:0] HVisEnd    = CoordW'(H_VIS);
    localparam logic [CoordW-1:0] VVisEnd    = CoordW'(V_VIS);
    localparam logic [CoordW-1:0] HSyncFirst = CoordW'(H_VIS + H_FP);
    localparam logic [CoordW-1:0] HSyncLast  = CoordW'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [CoordW-1:0] VSyncFirst = CoordW'(V_VIS + V_FP);
    localparam logic [CoordW-1:0] VSyncLast  = CoordW'(V_VIS + V_FP + V_SYNC - 1);

    logic [CoordW-1:0] x_q, x_d;
    logic [CoordW-1:0] y_q, y_d;
    logic              hsync_q, hsync_d;
    logic              vsync_q, vsync_d;
    logic              video_on_q, video_on_d;
    logic              frame_tick_q, frame_tick_d;
    logic              en;

    pixel_strobe_gen #(
        .DIV (DIV)
    ) u_pixel_strobe (
        .clk      (clk),
        .rst      (rst),
        .pixel_en (en)
    );

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (en) begin
            if (x_q != HLast) begin
                x_d = x_q + 1'b1;
            end else begin
                x_d = '0;
                y_d = (y_q == VLast) ? '0 : y_q + 1'b1;
            end
        end
    end

    // Decode from the next counter values so the registered outputs line up with pixel_x/y.
    always_comb begin
        hsync_d      = sync_level((x_d >= HSyncFirst) && (x_d <= HSyncLast));
        vsync_d      = sync_level((y_d >= VSyncFirst) && (y_d <= VSyncLast));
        video_on_d   = (x_d < HVisEnd) && (y_d < VVisEnd);
        frame_tick_d = en && (x_q == HLast) && (y_q == VLast);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q          <= '0;
            y_q          <= '0;
            hsync_q      <= ~SyncActive;
            vsync_q      <= ~SyncActive;
            video_on_q   <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            video_on_q   <= video_on_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign pixel_en   = en;
    assign pixel_x    = x_q;
    assign pixel_y    = y_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign video_on   = video_on_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench: full-size instance for line-level timing, shrunken instance for whole-frame behaviour.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Full 640x480 instance.
    logic       d_en, d_hs, d_vs, d_vo, d_ft;
    logic [9:0] d_x, d_y;
    // Shrunken raster: 25 x 17 pixels, DIV 4 -> 1700 clk per frame.
    logic       s_en, s_hs, s_vs, s_vo, s_ft;
    logic [9:0] s_x, s_y;

    vga_sync_gen u_dut_full (
        .clk        (clk),
        .rst        (rst),
        .pixel_en   (d_en),
        .pixel_x    (d_x),
        .pixel_y    (d_y),
        .hsync      (d_hs),
        .vsync      (d_vs),
        .video_on   (d_vo),
        .frame_tick (d_ft)
    );

    vga_sync_gen #(
        .DIV    (4),
        .H_VIS  (16),
        .H_FP   (2),
        .H_SYNC (4),
        .H_BP   (3),
        .V_VIS  (10),
        .V_FP   (2),
        .V_SYNC (2),
        .V_BP   (3)
    ) u_dut_small (
        .clk        (clk),
        .rst        (rst),
        .pixel_en   (s_en),
        .pixel_x    (s_x),
        .pixel_y    (s_y),
        .hsync      (s_hs),
        .vsync      (s_vs),
        .video_on   (s_vo),
        .frame_tick (s_ft)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Clk edges since reset release.
    int n = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) n <= 0;
        else     n <= n + 1;
    end

    typedef struct packed {
        logic       en;
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       vo;
        logic       ft;
    } exp_t;

    // Expected outputs after ncyc edges: pixel index = ncyc/div, raster position from that.
    function automatic exp_t model(input int ncyc, input int dv, input int hv, input int hf,
                                   input int hs, input int hb, input int vv, input int vf,
                                   input int vs, input int vb);
        exp_t e;
        int ht, vt, p, x, y;
        ht   = hv + hf + hs + hb;
        vt   = vv + vf + vs + vb;
        p    = ncyc / dv;
        x    = p % ht;
        y    = (p / ht) % vt;
        e.en = ((ncyc % dv) == dv - 1);
        e.x  = 10'(x);
        e.y  = 10'(y);
        e.hs = !((x >= hv + hf) && (x < hv + hf + hs));
        e.vs = !((y >= vv + vf) && (y < vv + vf + vs));
        e.vo = (x < hv) && (y < vv);
        e.ft = (p > 0) && ((p % (ht * vt)) == 0) && ((ncyc % dv) == 0);
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t ed, es;
        ed = model(n, 4, 640, 16, 96, 48, 480, 10, 2, 33);
        es = model(n, 4, 16, 2, 4, 3, 10, 2, 2, 3);
        chk("full.pixel_en", 32'(d_en), 32'(ed.en));
        chk("full.pixel_x", 32'(d_x), 32'(ed.x));
        chk("full.pixel_y", 32'(d_y), 32'(ed.y));
        chk("full.hsync", 32'(d_hs), 32'(ed.hs));
        chk("full.vsync", 32'(d_vs), 32'(ed.vs));
        chk("full.video_on", 32'(d_vo), 32'(ed.vo));
        chk("full.frame_tick", 32'(d_ft), 32'(ed.ft));
        chk("small.pixel_en", 32'(s_en), 32'(es.en));
        chk("small.pixel_x", 32'(s_x), 32'(es.x));
        chk("small.pixel_y", 32'(s_y), 32'(es.y));
        chk("small.hsync", 32'(s_hs), 32'(es.hs));
        chk("small.vsync", 32'(s_vs), 32'(es.vs));
        chk("small.video_on", 32'(s_vo), 32'(es.vo));
        chk("small.frame_tick", 32'(s_ft), 32'(es.ft));
    end

    // Counts clk cycles from release to first pixel_en, then pulse width and period.
    task automatic check_strobe_start(input string tag);
        int cyc;
        cyc = 1;
        while (!d_en && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, ".first_en_cycle"}, 32'(cyc), 32'd4);
        @(negedge clk);
        chk({tag, ".en_width"}, 32'(d_en), 32'd0);
        cyc = 1;
        while (!d_en && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, ".en_period"}, 32'(cyc), 32'd4);
    endtask

    initial begin
        int cyc, t0, vis;

        // Held reset: strobe and counters stay at zero.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold.pixel_en", 32'(d_en | s_en), 32'd0);
            chk("hold.pixel_x", 32'(d_x | s_x), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        check_strobe_start("start");

        // Line timing on the full-size instance.
        cyc = 0;
        while (d_hs && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        chk("hsync_fall_x", 32'(d_x), 32'd656);
        cyc = 0;
        while (!d_hs && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        chk("hsync_low_clks", 32'(cyc), 32'd384);
        chk("hsync_rise_x", 32'(d_x), 32'd752);
        cyc = 0;
        while (d_y != 10'd1 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        chk("line_wrap_x", 32'(d_x), 32'd0);
        chk("line_wrap_clks", 32'(n), 32'd3200);

        // Whole frames on the shrunken instance.
        cyc = 0;
        while (!s_ft && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        chk("frame_tick_seen", 32'(s_ft), 32'd1);
        chk("frame_start_x", 32'(s_x), 32'd0);
        chk("frame_start_y", 32'(s_y), 32'd0);
        t0  = n;
        vis = 0;
        cyc = 0;
        @(negedge clk);
        chk("frame_tick_width", 32'(s_ft), 32'd0);
        while (!s_ft && cyc < 2000) begin
            if (s_en && s_vo) vis++;
            @(negedge clk);
            cyc++;
        end
        chk("frame_period", 32'(n - t0), 32'd1700);
        chk("visible_pixels", 32'(vis), 32'd160);

        // Visible-area corners.
        cyc = 0;
        while (!(s_x == 10'd15 && s_y == 10'd9) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk("corner_last_vis", 32'(s_vo), 32'd1);
        while (!(s_x == 10'd16 && s_y == 10'd9) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk("corner_right_blank", 32'(s_vo), 32'd0);
        while (!(s_x == 10'd15 && s_y == 10'd10) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk("corner_below_blank", 32'(s_vo), 32'd0);

        // Asynchronous reset mid-frame, inside both sync pulses.
        cyc = 0;
        while (!(s_x == 10'd20 && s_y == 10'd12) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk("pre_reset_hsync", 32'(s_hs), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("areset.pixel_x", 32'(s_x | d_x), 32'd0);
        chk("areset.pixel_y", 32'(s_y | d_y), 32'd0);
        chk("areset.hsync", 32'(s_hs & d_hs), 32'd1);
        chk("areset.vsync", 32'(s_vs & d_vs), 32'd1);
        chk("areset.video_on", 32'(s_vo & d_vo), 32'd1);
        chk("areset.frame_tick", 32'(s_ft | d_ft), 32'd0);
        chk("areset.pixel_en", 32'(s_en | d_en), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold2.pixel_en", 32'(d_en | s_en), 32'd0);
            chk("hold2.counters", 32'(d_x | d_y | s_x | s_y), 32'd0);
        end
        rst = 1'b0;
        check_strobe_start("restart");
        repeat (20) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
